// File: rtl/packet_generator_pkg.sv
// Shared definitions for the packet generator: FSM states, LFSR polynomial, flit bit positions.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package packet_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Galois feedback taps for the 32-bit payload LFSR.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Head marker lives in the flit MSB, tail marker right below it.
    function automatic int head_pos(input int size);
        return size - 1;
    endfunction

    function automatic int tail_pos(input int size);
        return size - 2;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/packet_generator_if.sv
// Two-phase (toggle) flit channel: each req toggle presents a flit, each ack toggle accepts it.
// Latency: n/a (wires only).
// Backpressure: sink withholds the ack toggle; data must stay stable until it arrives.
interface packet_generator_if #(
    parameter int SIZE = 16
) ();
    logic            req;
    logic            ack;
    logic [SIZE-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/packet_generator_lfsr32.sv
// 32-bit Galois LFSR with seed reload and single-step enable.
// Latency: q updates one cycle after step/load_seed.
// Backpressure: none; holds its value while step is low.
// Ports: clk, reset (async active-low), load_seed, step, q[31:0].
module lfsr32
    import packet_generator_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_seed,
    input  logic        step,
    output logic [31:0] q
);
    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr_d;
    logic [31:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_seed) begin
            lfsr_d = SEED_EFF;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;
endmodule

// File: rtl/packet_generator.sv
// Traffic injector: emits PACKETS packets of FLITS LFSR-payload flits over a toggle req/ack channel.
// Latency: first req toggle 2 edges after reset release; 3-cycle minimum flit period; GAP+1 idle cycles between packets.
// Backpressure: holds each flit in WAIT until the ack toggle; enable is sampled only at packet boundaries.
// Ports: clk, reset (async active-low), enable, pkt (master: req/data out, ack in),
//        done, packets_sent[15:0], err (sticky: ack toggle seen outside WAIT).
module packet_generator
    import packet_generator_pkg::*;
#(
    parameter int          ID          = 0,
    parameter int          FLITS       = 8,
    parameter int          SIZE        = 16,
    parameter int          DEST_W      = 4,
    parameter int          DEST        = 0,
    parameter int          RANDOM_DEST = 0,
    parameter logic [31:0] SEED        = 32'h1,
    parameter int          PACKETS     = 2,
    parameter int          GAP         = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    packet_generator_if.master  pkt,
    output logic                done,
    output logic [15:0]         packets_sent,
    output logic                err
);
    localparam int          HEAD       = head_pos(SIZE);
    localparam int          TAIL       = tail_pos(SIZE);
    localparam logic [7:0]  LAST_FLIT  = 8'(FLITS - 1);
    localparam logic [7:0]  GAP_LEN    = 8'(GAP);
    localparam logic [15:0] PKT_TARGET = 16'(PACKETS);

    state_e          state_d, state_q;
    logic            req_d, req_q;
    logic [SIZE-1:0] data_d, data_q;
    logic            done_d, done_q;
    logic            err_d, err_q;
    logic [15:0]     sent_d, sent_q;
    logic [7:0]      flit_idx_d, flit_idx_q;
    logic [7:0]      gap_cnt_d, gap_cnt_q;
    logic            ack_smp_d, ack_smp_q;
    logic            ack_old_d, ack_old_q;

    logic            ack_rx;
    logic            lfsr_step;
    logic [31:0]     lfsr_q;
    logic [SIZE-1:0] flit;
    logic [DEST_W-1:0] dest;

    // Only kept so the instance number survives in the netlist for debug.
    logic [31:0] dbg_id_unused;
    logic        lfsr_unused;
    assign dbg_id_unused = 32'(ID);
    assign lfsr_unused   = ^lfsr_q;

    lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load_seed (1'b0),
        .step      (lfsr_step),
        .q         (lfsr_q)
    );

    // ack is registered once before edge detection, so an ack toggle landing
    // before edge k raises ack_rx for the whole cycle following edge k.
    assign ack_rx = ack_smp_q ^ ack_old_q;

    assign dest = (RANDOM_DEST != 0) ? lfsr_q[DEST_W-1:0] : DEST_W'(DEST);

    // Flit assembled from the current LFSR value; the LFSR steps as it is sent.
    always_comb begin
        flit             = '0;
        flit[SIZE-3:0]   = lfsr_q[SIZE-3:0];
        if (flit_idx_q == 8'd0) begin
            flit[DEST_W-1:0] = dest;
        end
        flit[HEAD] = (flit_idx_q == 8'd0);
        flit[TAIL] = (flit_idx_q == LAST_FLIT);
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        done_d     = done_q;
        err_d      = err_q;
        sent_d     = sent_q;
        flit_idx_d = flit_idx_q;
        gap_cnt_d  = gap_cnt_q;
        ack_smp_d  = pkt.ack;
        ack_old_d  = ack_smp_q;
        lfsr_step  = 1'b0;

        // An ack toggle we did not ask for is flagged but never moves the FSM.
        if (ack_rx && (state_q != ST_WAIT)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((PACKETS != 0) && (sent_q == PKT_TARGET)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (enable) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                data_d    = flit;
                req_d     = ~req_q;
                lfsr_step = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_rx) begin
                    if (flit_idx_q != LAST_FLIT) begin
                        flit_idx_d = flit_idx_q + 8'd1;
                        state_d    = ST_SEND;
                    end else begin
                        flit_idx_d = 8'd0;
                        sent_d     = sent_q + 16'd1;
                        if (GAP > 0) begin
                            gap_cnt_d = GAP_LEN;
                            state_d   = ST_GAP;
                        end else begin
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sent_q     <= 16'd0;
            flit_idx_q <= 8'd0;
            gap_cnt_q  <= 8'd0;
            ack_smp_q  <= 1'b0;
            ack_old_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sent_q     <= sent_d;
            flit_idx_q <= flit_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            ack_smp_q  <= ack_smp_d;
            ack_old_q  <= ack_old_d;
        end
    end

    assign pkt.req      = req_q;
    assign pkt.data     = data_q;
    assign done         = done_q;
    assign packets_sent = sent_q;
    assign err          = err_q;
endmodule

// File: tb/tb_packet_generator.sv
// Bench for packet_generator: three instances with different configurations, a randomized-delay
// toggle sink per instance, and a flit/timing reference model built from the protocol rules.
module tb_packet_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst_n [3];
    logic        en    [3];
    logic        ack_r [3];
    logic        req_w [3];
    logic [15:0] data_w[3];
    logic        done_w[3];
    logic [15:0] ps_w  [3];
    logic        err_w [3];

    // Per-instance configuration, mirrored into the reference model.
    int          cfg_flits[3] = '{8, 1, 3};
    int          cfg_gap  [3] = '{0, 4, 2};
    int          cfg_dest [3] = '{0, 10, 0};
    int          cfg_rnd  [3] = '{0, 0, 1};
    logic [31:0] cfg_seed [3] = '{32'h1, 32'h1, 32'hACE1};

    packet_generator_if #(.SIZE(16)) pif0 ();
    packet_generator_if #(.SIZE(16)) pif1 ();
    packet_generator_if #(.SIZE(16)) pif2 ();

    assign pif0.ack = ack_r[0];
    assign pif1.ack = ack_r[1];
    assign pif2.ack = ack_r[2];
    assign req_w[0] = pif0.req;
    assign req_w[1] = pif1.req;
    assign req_w[2] = pif2.req;
    assign data_w[0] = pif0.data;
    assign data_w[1] = pif1.data;
    assign data_w[2] = pif2.data;

    packet_generator #(.ID(0)) dut0 (
        .clk(clk), .reset(rst_n[0]), .enable(en[0]), .pkt(pif0),
        .done(done_w[0]), .packets_sent(ps_w[0]), .err(err_w[0]));

    packet_generator #(.ID(1), .FLITS(1), .PACKETS(3), .GAP(4), .DEST(10)) dut1 (
        .clk(clk), .reset(rst_n[1]), .enable(en[1]), .pkt(pif1),
        .done(done_w[1]), .packets_sent(ps_w[1]), .err(err_w[1]));

    packet_generator #(.ID(2), .FLITS(3), .PACKETS(0), .GAP(2), .RANDOM_DEST(1),
                       .SEED(32'hACE1)) dut2 (
        .clk(clk), .reset(rst_n[2]), .enable(en[2]), .pkt(pif2),
        .done(done_w[2]), .packets_sent(ps_w[2]), .err(err_w[2]));

    // Sink capture: every req toggle is logged with its edge number and the
    // random ack delay (in cycles) chosen for it.
    logic [15:0] got_dat[3][$];
    int          got_cyc[3][$];
    int          got_dly[3][$];
    logic        req_prev[3];
    bit          pend[3];
    int          cnt[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; en[k] = 1'b0; ack_r[k] = 1'b0;
            req_prev[k] = 1'b0; pend[k] = 1'b0; cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n[k]) begin
                    req_prev[k] = 1'b0;
                    pend[k]     = 1'b0;
                end else begin
                    if (pend[k] && cnt[k] == 0) begin
                        ack_r[k] = ~ack_r[k];
                        pend[k]  = 1'b0;
                    end else if (pend[k]) begin
                        cnt[k] = cnt[k] - 1;
                    end
                    if (req_w[k] !== req_prev[k]) begin
                        int d;
                        req_prev[k] = req_w[k];
                        d = int'($urandom_range(2, 0));
                        got_dat[k].push_back(data_w[k]);
                        got_cyc[k].push_back(cyc);
                        got_dly[k].push_back(d);
                        if (d == 0) ack_r[k] = ~ack_r[k];
                        else begin pend[k] = 1'b1; cnt[k] = d - 1; end
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    logic [3:0]  exp_lo[$];

    function automatic logic [31:0] lfsr_m(input logic [31:0] l);
        if (l % 2 == 1) return (l / 2) ^ 32'h8020_0003;
        return l / 2;
    endfunction

    task automatic build_model(input int k, input int n);
        logic [31:0] l;
        int idx, v, dst;
        exp_q.delete();
        exp_lo.delete();
        l = cfg_seed[k];
        for (int j = 0; j < n; j++) begin
            idx = j % cfg_flits[k];
            v   = int'(l % 32'd16384);
            dst = (cfg_rnd[k] != 0) ? int'(l % 32'd16) : cfg_dest[k];
            if (idx == 0) v = (v / 16) * 16 + dst + 32768;
            if (idx == cfg_flits[k] - 1) v = v + 16384;
            exp_q.push_back(v[15:0]);
            exp_lo.push_back(l[3:0]);
            l = lfsr_m(l);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset(input int k, input logic en_val);
        rst_n[k] = 1'b0;
        ack_r[k] = 1'b0;
        en[k]    = en_val;
        got_dat[k].delete(); got_cyc[k].delete(); got_dly[k].delete();
        tick(2);
        rst_n[k] = 1'b1;
    endtask

    task automatic wait_flits(input int k, input int n, input int budget, input string tag);
        int c = 0;
        while (got_dat[k].size() < n && c < budget) begin tick(1); c++; end
        total++;
        if (got_dat[k].size() < n) begin
            bad++;
            $display("FAIL %s wait: got %0d flits, need %0d", tag, got_dat[k].size(), n);
        end
    endtask

    // Data vs model for all n flits; edge timing for 1 <= j < n_time.
    // Next toggle = prev toggle edge + ack delay + 3, plus GAP+1 at packet boundaries.
    task automatic check_flits(input int k, input int n, input int n_time, input string tag);
        int ex;
        build_model(k, n);
        for (int j = 0; j < n && j < got_dat[k].size(); j++) begin
            total++;
            if (got_dat[k][j] !== exp_q[j]) begin
                bad++;
                $display("FAIL %s flit%0d: got %h want %h", tag, j, got_dat[k][j], exp_q[j]);
            end
            if (j > 0 && j < n_time) begin
                ex = got_cyc[k][j-1] + got_dly[k][j-1] + 3 +
                     ((j % cfg_flits[k] == 0) ? cfg_gap[k] + 1 : 0);
                total++;
                if (got_cyc[k][j] != ex) begin
                    bad++;
                    $display("FAIL %s time%0d: got edge %0d want %0d", tag, j, got_cyc[k][j], ex);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({req_w[k], data_w[k], done_w[k], err_w[k], ps_w[k]} !== 35'd0) begin
                bad++;
                $display("FAIL reset%0d: req=%b data=%h done=%b err=%b ps=%0d want all 0",
                         k, req_w[k], data_w[k], done_w[k], err_w[k], ps_w[k]);
            end
        end
    endtask

    task automatic test_basic();
        int rel, c;
        logic [15:0] f;
        do_reset(0, 1'b1);
        rel = cyc;
        wait_flits(0, 16, 400, "basic");
        total++;
        if (got_cyc[0].size() > 0 && got_cyc[0][0] != rel + 2) begin
            bad++;
            $display("FAIL basic first_req: got edge %0d want %0d", got_cyc[0][0], rel + 2);
        end
        check_flits(0, 16, 16, "basic");
        if (got_dat[0].size() >= 8) begin
            f = got_dat[0][0];
            total++;
            if ({f[15], f[3:0]} !== 5'b10000) begin
                bad++; $display("FAIL basic head: got %h want 8xx0", f);
            end
            f = got_dat[0][7];
            total++;
            if (f[14] !== 1'b1) begin
                bad++; $display("FAIL basic tail: got %h want bit14=1", f);
            end
        end
        c = 0;
        while (ps_w[0] != 16'd2 && c < 100) begin tick(1); c++; end
        total++;
        if (done_w[0] !== 1'b0 || ps_w[0] !== 16'd2) begin
            bad++; $display("FAIL basic done_early: done=%b ps=%0d want 0/2", done_w[0], ps_w[0]);
        end
        tick(1);
        total++;
        if (done_w[0] !== 1'b1 || err_w[0] !== 1'b0) begin
            bad++; $display("FAIL basic done: done=%b err=%b want 1/0", done_w[0], err_w[0]);
        end
    endtask

    task automatic test_reset_midpacket();
        logic [15:0] f0;
        do_reset(0, 1'b1);
        wait_flits(0, 3, 200, "midrst");
        f0 = (got_dat[0].size() > 0) ? got_dat[0][0] : 16'h0;
        rst_n[0] = 1'b0;
        ack_r[0] = 1'b0;
        #1;
        total++;
        if (req_w[0] !== 1'b0 || data_w[0] !== 16'h0) begin
            bad++; $display("FAIL midrst async: req=%b data=%h want 0/0000", req_w[0], data_w[0]);
        end
        do_reset(0, 1'b1);
        wait_flits(0, 16, 400, "midrst");
        total++;
        if (got_dat[0].size() > 0 && got_dat[0][0] !== f0) begin
            bad++; $display("FAIL midrst restart: got %h want %h", got_dat[0][0], f0);
        end
        check_flits(0, 16, 16, "midrst");
    endtask

    task automatic test_spurious();
        int c;
        do_reset(0, 1'b0);
        tick(3);
        ack_r[0] = ~ack_r[0];
        tick(4);
        total++;
        if (err_w[0] !== 1'b1 || req_w[0] !== 1'b0 || got_dat[0].size() != 0) begin
            bad++;
            $display("FAIL spurious err: err=%b req=%b flits=%0d want 1/0/0",
                     err_w[0], req_w[0], got_dat[0].size());
        end
        en[0] = 1'b1;
        wait_flits(0, 16, 400, "spurious");
        check_flits(0, 16, 16, "spurious");
        c = 0;
        while (done_w[0] !== 1'b1 && c < 100) begin tick(1); c++; end
        total++;
        if (ps_w[0] !== 16'd2 || done_w[0] !== 1'b1 || err_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL spurious end: ps=%0d done=%b err=%b want 2/1/1", ps_w[0], done_w[0], err_w[0]);
        end
    endtask

    task automatic test_gap();
        int c;
        logic [15:0] f;
        do_reset(1, 1'b1);
        wait_flits(1, 3, 400, "gap");
        check_flits(1, 3, 3, "gap");
        for (int j = 0; j < 3 && j < got_dat[1].size(); j++) begin
            f = got_dat[1][j];
            total++;
            if (f[15:14] !== 2'b11 || f[3:0] !== 4'hA) begin
                bad++; $display("FAIL gap flit%0d marks: got %h want 11xx_..._A", j, f);
            end
            if (j > 0) begin
                total++;
                if (got_cyc[1][j] - (got_cyc[1][j-1] + got_dly[1][j-1]) < 5) begin
                    bad++;
                    $display("FAIL gap spacing%0d: got %0d cycles want >=5", j,
                             got_cyc[1][j] - (got_cyc[1][j-1] + got_dly[1][j-1]));
                end
            end
        end
        c = 0;
        while (done_w[1] !== 1'b1 && c < 100) begin tick(1); c++; end
        tick(20);
        total++;
        if (ps_w[1] !== 16'd3 || done_w[1] !== 1'b1 || err_w[1] !== 1'b0 || got_dat[1].size() != 3) begin
            bad++;
            $display("FAIL gap end: ps=%0d done=%b err=%b flits=%0d want 3/1/0/3",
                     ps_w[1], done_w[1], err_w[1], got_dat[1].size());
        end
    endtask

    task automatic test_enable_gating();
        logic r0;
        do_reset(2, 1'b1);
        wait_flits(2, 13, 800, "gating");
        en[2] = 1'b0;
        wait_flits(2, 15, 200, "gating");
        tick(10);
        r0 = req_w[2];
        tick(40);
        total++;
        if (req_w[2] !== r0 || got_dat[2].size() != 15 || ps_w[2] !== 16'd5 ||
            done_w[2] !== 1'b0 || err_w[2] !== 1'b0) begin
            bad++;
            $display("FAIL gating hold: flits=%0d ps=%0d done=%b err=%b want 15/5/0/0",
                     got_dat[2].size(), ps_w[2], done_w[2], err_w[2]);
        end
        en[2] = 1'b1;
        wait_flits(2, 18, 200, "gating");
        check_flits(2, 18, 15, "gating");
        for (int j = 0; j < 18 && j < got_dat[2].size(); j += 3) begin
            total++;
            if (got_dat[2][j][3:0] !== exp_lo[j]) begin
                bad++; $display("FAIL rdest pkt%0d: got %h want %h", j / 3, got_dat[2][j][3:0], exp_lo[j]);
            end
        end
    endtask

    initial begin
        tick(2);
        test_reset();
        test_basic();
        test_reset_midpacket();
        test_spurious();
        test_gap();
        test_enable_gating();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
